sync_fifo: RTL and testbench
============================

// Module: sync_fifo
// PURPOSE
//  Single-clock parametrised FIFO; successor to the dual-clock FIFO for same-domain buffering.
//  Same p_write_*/p_read_* handshake, plus everything the dual-clock FIFO lacks:
//  programmable almost-full/almost-empty, exact fill level, FWFT or standard read mode,
//  synchronous flush, sticky overflow/underflow flags. Any SIZE >= 2 (not only power of two).
// PARAMETERS
//  BITS     32        width of each entry
//  SIZE     16        number of entries, >= 2
//  FWFT     0         0: standard read (data one cycle after p_read_en); 1: first-word-fall-through
//  AF_TH    SIZE-2    p_write_almost_full asserted when level >= AF_TH (1..SIZE)
//  AE_TH    2         p_read_almost_empty asserted when level <= AE_TH (0..SIZE-1)
//  LW       $clog2(SIZE+1)  level width (derived, do not override)
// PORTS
//  clk                 in   1     single clock, rising edge
//  rst_n               in   1     asynchronous active-low reset
//  p_clear             in   1     synchronous flush; empties FIFO, clears sticky flags
//  p_write_en          in   1     write request
//  p_write_data        in   BITS  data to write
//  p_write_full        out  1     level == SIZE
//  p_write_almost_full out  1     level >= AF_TH
//  p_read_en           in   1     read request
//  p_read_data         out  BITS  read data (timing per FWFT)
//  p_read_empty        out  1     level == 0
//  p_read_almost_empty out  1     level <= AE_TH
//  p_level             out  LW    current entry count, 0..SIZE
//  p_overflow          out  1     sticky: rejected write seen
//  p_underflow         out  1     sticky: rejected read seen
// BEHAVIOUR
//  - Reset (rst_n=0, async): pointers=0, level=0, empty=1, full=0, almost_empty=1,
//    almost_full=(AF_TH==0 ? 1 : 0), overflow=underflow=0, p_read_data=0.
//  - All flags and level come from registered state; no combinational input->output path.
//  - Accept: rd_ok = p_read_en & !empty; wr_ok = p_write_en & (!full | rd_ok).
//    Full + both requested: both accepted, level unchanged.
//    Empty + both requested: write accepted, read rejected (underflow set).
//  - Rejected write sets p_overflow; rejected read sets p_underflow. Both sticky until
//    p_clear or reset. Memory and pointers are not modified by a rejected operation.
//  - Level: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
//    Updates at the edge of acceptance; flags follow in the same cycle as level.
//  - Pointers wrap SIZE-1 -> 0 by explicit compare (no power-of-two masking).
//  - FWFT=0: p_read_data loads mem[rd_ptr] at the edge where rd_ok=1 and holds otherwise.
//    Latency is 1 cycle from p_read_en to valid data.
//  - FWFT=1: p_read_data = mem[rd_ptr] whenever !empty, 0 when empty; rd_ok pops.
//    A write into an empty FIFO is visible on p_read_data in the cycle empty drops.
//  - p_clear=1 has priority over write/read that cycle: next cycle level=0, pointers=0,
//    sticky flags=0. In FWFT=0, p_read_data holds its last value; in FWFT=1 it shows 0 (empty).
//  - Reset mid-operation discards contents immediately; memory array is not reset.
// STRUCTURE
//  - sync_fifo_pkg: function level_width(size), typedef enum {READ_STD, READ_FWFT} read_mode_e,
//    parameter checks (SIZE>=2, AF_TH/AE_TH in range) as elaboration-time $fatal.
//  - Sub-module fifo_ram #(BITS,SIZE): 1 sync write port, 1 async read port, no reset.
//  - Top holds pointers, level counter, flags and the output data register.
// TESTING
//  1. Reset: hold rst_n=0 for 3 clk -> empty=1, full=0, level=0, ae=1, af=0, flags=0.
//  2. SIZE=16: write 16 (0..15) -> full=1, level=16, af=1 from level 14;
//     17th write -> overflow=1, level stays 16; read 16 -> data 0..15 in order, empty=1.
//  3. Full + simultaneous read/write for 8 cycles -> level stays 16, full stays 1,
//     no overflow, data order preserved.
//  4. Empty, read_en=1 -> underflow=1, data unchanged; FWFT=1: write 0xA5 ->
//     next cycle empty=0 and p_read_data=0xA5 with no read issued.
//  5. SIZE=5 wrap: 3 writes / 3 reads repeated 10 times -> ordered data, no flags set, level 0 at end.
//  6. Write 6, p_clear + write_en same cycle -> next cycle level=0, empty=1, overflow cleared;
//     write after clear reads back correctly.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_pkg
// Brief    : Shared types and elaboration helpers for the single-clock FIFO.
// Revision : 1.0
// ============================================================================
package sync_fifo_pkg;

    typedef enum logic {
        READ_STD  = 1'b0,
        READ_FWFT = 1'b1
    } read_mode_e;

    function automatic int level_width(input int size);
        return $clog2(size + 1);
    endfunction

    function automatic bit params_ok(input int size, input int af_th, input int ae_th);
        return (size >= 2) && (af_th >= 1) && (af_th <= size) &&
               (ae_th >= 0) && (ae_th <= size - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_if
// Brief    : Write/read handshake bundle between a FIFO user and sync_fifo.
// Revision : 1.0
// ============================================================================
interface sync_fifo_if #(
    parameter int BITS = 32,
    parameter int SIZE = 16
);
    localparam int LW = sync_fifo_pkg::level_width(SIZE);

    logic            p_clear;
    logic            p_write_en;
    logic [BITS-1:0] p_write_data;
    logic            p_write_full;
    logic            p_write_almost_full;
    logic            p_read_en;
    logic [BITS-1:0] p_read_data;
    logic            p_read_empty;
    logic            p_read_almost_empty;
    logic [LW-1:0]   p_level;
    logic            p_overflow;
    logic            p_underflow;

    modport master (
        output p_clear, p_write_en, p_write_data, p_read_en,
        input  p_write_full, p_write_almost_full, p_read_data, p_read_empty,
               p_read_almost_empty, p_level, p_overflow, p_underflow
    );

    modport slave (
        input  p_clear, p_write_en, p_write_data, p_read_en,
        output p_write_full, p_write_almost_full, p_read_data, p_read_empty,
               p_read_almost_empty, p_level, p_overflow, p_underflow
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ram
// Brief    : Storage array, one synchronous write port, one async read port.
// Revision : 1.0
// ============================================================================
module fifo_ram #(
    parameter int BITS = 32,
    parameter int SIZE = 16
) (
    input  wire logic                    clk,
    input  wire logic                    i_we,
    input  wire logic [$clog2(SIZE)-1:0] i_waddr,
    input  wire logic [BITS-1:0]         i_wdata,
    input  wire logic [$clog2(SIZE)-1:0] i_raddr,
    output      logic [BITS-1:0]         o_rdata
);
    logic [BITS-1:0] r_mem [SIZE];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with level, thresholds, flush, FWFT/standard read.
// Revision : 1.0
// ============================================================================
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int BITS  = 32,
    parameter int SIZE  = 16,
    parameter int FWFT  = 0,
    parameter int AF_TH = SIZE - 2,
    parameter int AE_TH = 2
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    sync_fifo_if.slave   fifo
);
    localparam int                LW         = level_width(SIZE);
    localparam int                AW         = $clog2(SIZE);
    localparam logic [AW-1:0]     c_ptr_last = AW'(SIZE - 1);
    localparam logic [AW-1:0]     c_ptr_one  = AW'(1);
    localparam logic [LW-1:0]     c_lvl_one  = LW'(1);
    localparam logic [LW-1:0]     c_lvl_full = LW'(SIZE);
    localparam logic [LW-1:0]     c_af_th    = LW'(AF_TH);
    localparam logic [LW-1:0]     c_ae_th    = LW'(AE_TH);
    localparam read_mode_e        c_mode     = (FWFT != 0) ? READ_FWFT : READ_STD;

    generate
        if (!params_ok(SIZE, AF_TH, AE_TH)) begin : g_param_check
            $fatal(1, "sync_fifo: SIZE must be >= 2, AF_TH in 1..SIZE, AE_TH in 0..SIZE-1");
        end
    endgenerate

    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic            r_overflow;
    logic            r_underflow;
    logic [BITS-1:0] r_rd_data;
    logic [BITS-1:0] w_ram_data;
    logic            w_empty;
    logic            w_full;
    logic            w_rd_ok;
    logic            w_wr_ok;
    logic            w_ram_we;

    assign w_empty  = (r_level == '0);
    assign w_full   = (r_level == c_lvl_full);
    assign w_rd_ok  = fifo.p_read_en & ~w_empty;
    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    assign w_wr_ok  = fifo.p_write_en & (~w_full | w_rd_ok);
    assign w_ram_we = w_wr_ok & ~fifo.p_clear;

    fifo_ram #(
        .BITS (BITS),
        .SIZE (SIZE)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (fifo.p_write_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_rd_data   <= '0;
        end else if (fifo.p_clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + c_ptr_one;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + c_ptr_one;
            end
            if (w_wr_ok && !w_rd_ok) begin
                r_level <= r_level + c_lvl_one;
            end else if (w_rd_ok && !w_wr_ok) begin
                r_level <= r_level - c_lvl_one;
            end
            if (fifo.p_write_en && !w_wr_ok) begin
                r_overflow <= 1'b1;
            end
            if (fifo.p_read_en && !w_rd_ok) begin
                r_underflow <= 1'b1;
            end
            if ((c_mode == READ_STD) && w_rd_ok) begin
                r_rd_data <= w_ram_data;
            end
        end
    end

    assign fifo.p_read_data         = (c_mode == READ_FWFT) ? (w_empty ? '0 : w_ram_data)
                                                            : r_rd_data;
    assign fifo.p_write_full        = w_full;
    assign fifo.p_write_almost_full = (r_level >= c_af_th);
    assign fifo.p_read_empty        = w_empty;
    assign fifo.p_read_almost_empty = (r_level <= c_ae_th);
    assign fifo.p_level             = r_level;
    assign fifo.p_overflow          = r_overflow;
    assign fifo.p_underflow         = r_underflow;
endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo
// Brief    : Self-checking bench: three FIFO configurations against a queue model.
// Revision : 1.0
// ============================================================================
module tb_sync_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] wd = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Instance 0: SIZE 16 standard, 1: SIZE 16 FWFT, 2: SIZE 5 standard.
    sync_fifo_if #(.BITS(32), .SIZE(16)) if_a ();
    sync_fifo_if #(.BITS(32), .SIZE(16)) if_b ();
    sync_fifo_if #(.BITS(32), .SIZE(5))  if_c ();

    assign if_a.p_clear = clr;  assign if_a.p_write_en = we;
    assign if_a.p_read_en = re; assign if_a.p_write_data = wd;
    assign if_b.p_clear = clr;  assign if_b.p_write_en = we;
    assign if_b.p_read_en = re; assign if_b.p_write_data = wd;
    assign if_c.p_clear = clr;  assign if_c.p_write_en = we;
    assign if_c.p_read_en = re; assign if_c.p_write_data = wd;

    sync_fifo #(.BITS(32), .SIZE(16), .FWFT(0)) dut_a (.clk(clk), .rst_n(rst_n), .fifo(if_a));
    sync_fifo #(.BITS(32), .SIZE(16), .FWFT(1)) dut_b (.clk(clk), .rst_n(rst_n), .fifo(if_b));
    sync_fifo #(.BITS(32), .SIZE(5),  .FWFT(0)) dut_c (.clk(clk), .rst_n(rst_n), .fifo(if_c));

    // {data, level, full, almost_full, empty, almost_empty, overflow, underflow}
    logic [42:0] obs [3];
    assign obs[0] = {if_a.p_read_data, if_a.p_level, if_a.p_write_full, if_a.p_write_almost_full,
                     if_a.p_read_empty, if_a.p_read_almost_empty, if_a.p_overflow, if_a.p_underflow};
    assign obs[1] = {if_b.p_read_data, if_b.p_level, if_b.p_write_full, if_b.p_write_almost_full,
                     if_b.p_read_empty, if_b.p_read_almost_empty, if_b.p_overflow, if_b.p_underflow};
    assign obs[2] = {if_c.p_read_data, 2'b00, if_c.p_level, if_c.p_write_full, if_c.p_write_almost_full,
                     if_c.p_read_empty, if_c.p_read_almost_empty, if_c.p_overflow, if_c.p_underflow};

    // Reference model: a plain queue per instance plus the last popped word and sticky flags.
    logic [31:0] mq [3][$];
    logic [31:0] m_rd [3];
    bit          m_ovf [3];
    bit          m_unf [3];

    function automatic int sz(input int k);
        return (k == 2) ? 5 : 16;
    endfunction

    function automatic bit is_fwft(input int k);
        return (k == 1);
    endfunction

    function automatic logic [42:0] exp_st(input int k);
        int          n;
        logic [31:0] d;
        n = mq[k].size();
        if (is_fwft(k)) d = (n == 0) ? 32'h0 : mq[k][0];
        else            d = m_rd[k];
        return {d, 5'(n), n == sz(k), n >= sz(k) - 2, n == 0, n <= 2, m_ovf[k], m_unf[k]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mq[k].delete();
            m_rd[k]  = '0;
            m_ovf[k] = 1'b0;
            m_unf[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit          rok, wok;
        logic [31:0] h;
        for (int k = 0; k < 3; k++) begin
            if (clr) begin
                mq[k].delete();
                m_ovf[k] = 1'b0;
                m_unf[k] = 1'b0;
            end else begin
                rok = re && (mq[k].size() > 0);
                wok = we && ((mq[k].size() < sz(k)) || rok);
                if (rok) begin
                    h = mq[k].pop_front();
                    if (!is_fwft(k)) m_rd[k] = h;
                end
                if (wok) mq[k].push_back(wd);
                if (we && !wok) m_ovf[k] = 1'b1;
                if (re && !rok) m_unf[k] = 1'b1;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, return on the falling edge.
    task automatic cyc(input bit c, input bit w, input logic [31:0] d, input bit r);
        clr = c; we = w; wd = d; re = r;
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        @(negedge clk);
        clr = 1'b0; we = 1'b0; re = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) cyc(1'($urandom), 1'($urandom), $urandom, 1'($urandom));
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs[k] !== exp_st(k)) begin
                n_errors++;
                $display("FAIL reset dut%0d: got %h, expected %h", k, obs[k], exp_st(k));
            end
        end
        rst_n = 1'b1;
        cyc(0, 0, '0, 0);
    endtask

    task automatic test_fill_drain();
        cyc(1, 0, '0, 0);
        for (int i = 0; i < 17; i++) begin
            cyc(0, 1, 32'(i), 0);
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (obs[k] !== exp_st(k)) begin
                    n_errors++;
                    $display("FAIL fill[%0d] dut%0d: got %h, expected %h", i, k, obs[k], exp_st(k));
                end
            end
        end
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, '0, 1);
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (obs[k] !== exp_st(k)) begin
                    n_errors++;
                    $display("FAIL drain[%0d] dut%0d: got %h, expected %h", i, k, obs[k], exp_st(k));
                end
            end
        end
        n_checks++;
        if (if_a.p_read_data !== 32'd15 || if_a.p_read_empty !== 1'b1) begin
            n_errors++;
            $display("FAIL drain_last: data %h empty %b, expected 0000000f and 1",
                     if_a.p_read_data, if_a.p_read_empty);
        end
    endtask

    task automatic test_full_rw();
        cyc(1, 0, '0, 0);
        for (int i = 0; i < 16; i++) cyc(0, 1, $urandom, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, $urandom, 1);
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (obs[k] !== exp_st(k)) begin
                    n_errors++;
                    $display("FAIL full_rw[%0d] dut%0d: got %h, expected %h", i, k, obs[k], exp_st(k));
                end
            end
        end
        n_checks++;
        if (if_a.p_level !== 5'd16 || if_a.p_overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL full_rw_level: level %0d ovf %b, expected 16 and 0", if_a.p_level, if_a.p_overflow);
        end
    endtask

    task automatic test_underflow_fwft();
        cyc(1, 0, '0, 0);
        cyc(0, 0, '0, 1);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs[k] !== exp_st(k)) begin
                n_errors++;
                $display("FAIL underflow dut%0d: got %h, expected %h", k, obs[k], exp_st(k));
            end
        end
        cyc(0, 1, 32'hA5, 0);
        n_checks++;
        if (if_b.p_read_data !== 32'hA5 || if_b.p_read_empty !== 1'b0) begin
            n_errors++;
            $display("FAIL fwft_fall: data %h empty %b, expected 000000a5 and 0",
                     if_b.p_read_data, if_b.p_read_empty);
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs[k] !== exp_st(k)) begin
                n_errors++;
                $display("FAIL fwft_write dut%0d: got %h, expected %h", k, obs[k], exp_st(k));
            end
        end
    endtask

    task automatic test_wrap();
        cyc(1, 0, '0, 0);
        for (int rep = 0; rep < 10; rep++) begin
            for (int i = 0; i < 3; i++) cyc(0, 1, $urandom, 0);
            for (int i = 0; i < 3; i++) begin
                cyc(0, 0, '0, 1);
                for (int k = 0; k < 3; k++) begin
                    n_checks++;
                    if (obs[k] !== exp_st(k)) begin
                        n_errors++;
                        $display("FAIL wrap[%0d.%0d] dut%0d: got %h, expected %h", rep, i, k, obs[k], exp_st(k));
                    end
                end
            end
        end
        n_checks++;
        if (if_c.p_level !== 3'd0 || if_c.p_overflow !== 1'b0 || if_c.p_underflow !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap_end: level %0d ovf %b unf %b, expected 0 0 0",
                     if_c.p_level, if_c.p_overflow, if_c.p_underflow);
        end
    endtask

    task automatic test_clear();
        cyc(1, 0, '0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 1, 32'h100 + 32'(i), 0);
        cyc(1, 1, 32'hDEAD, 0);
        n_checks++;
        if (if_a.p_level !== 5'd0 || if_a.p_read_empty !== 1'b1 || if_c.p_overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL clear: level %0d empty %b ovf %b, expected 0 1 0",
                     if_a.p_level, if_a.p_read_empty, if_c.p_overflow);
        end
        cyc(0, 1, 32'h1234_5678, 0);
        cyc(0, 0, '0, 1);
        n_checks++;
        if (if_a.p_read_data !== 32'h1234_5678) begin
            n_errors++;
            $display("FAIL clear_rd: got %h, expected 12345678", if_a.p_read_data);
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs[k] !== exp_st(k)) begin
                n_errors++;
                $display("FAIL clear_model dut%0d: got %h, expected %h", k, obs[k], exp_st(k));
            end
        end
    endtask

    task automatic test_random();
        bit c, w, r;
        for (int i = 0; i < 400; i++) begin
            c = ($urandom_range(0, 39) == 0);
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 45);
            cyc(c, w, $urandom, r);
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (obs[k] !== exp_st(k)) begin
                    n_errors++;
                    $display("FAIL random[%0d] dut%0d: got %h, expected %h", i, k, obs[k], exp_st(k));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) cyc(0, 1, $urandom, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs[k] !== exp_st(k)) begin
                n_errors++;
                $display("FAIL async_reset dut%0d: got %h, expected %h", k, obs[k], exp_st(k));
            end
        end
        cyc(0, 0, '0, 0);
        rst_n = 1'b1;
        cyc(0, 0, '0, 0);
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full_rw();
        test_underflow_fwft();
        test_wrap();
        test_clear();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
